sqrt_dispatch: RTL and testbench
================================

SQRT_DISPATCH -- requirements
Module: sqrt_dispatch

Interface
REQ-001 Parameter DEPTH, default 4, meaning input FIFO depth in operands (power of 2, >=2).
REQ-002 Parameter TIMEOUT, default 64, meaning max cycles waited for core eop before error.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_val  input  32  unsigned operand to be square-rooted.
REQ-006 in_valid  input  1  in_val is valid this cycle.
REQ-007 in_ready  output  1  FIFO not full; operand accepted when in_valid & in_ready.
REQ-008 core_val  output  32  operand presented to the sqrt core.
REQ-009 core_start_n  output  1  active-low one-cycle start pulse to the sqrt core (drives the core's rst).
REQ-010 core_out  input  16  core result, floor(sqrt(core_val)).
REQ-011 core_eop  input  1  core end-of-operation, level; completion on its rising edge.
REQ-012 res_out  output  16  result.
REQ-013 res_val  output  32  operand that produced res_out.
REQ-014 res_valid  output  1  result pending.
REQ-015 res_ready  input  1  consumer takes result when res_valid & res_ready.
REQ-016 err  output  1  sticky timeout flag.

Function
REQ-017 Input FIFO SHALL hold DEPTH operands, first-in-first-out; in_ready = not full; push on in_valid & in_ready.
REQ-018 Push while full SHALL NOT occur (in_ready=0); push and pop in same cycle SHALL both take effect, count unchanged.
REQ-019 FSM states: IDLE, LAUNCH, WAIT, HOLD.
REQ-020 IDLE: if FIFO non-empty, pop head into core_val register, go LAUNCH; else stay.
REQ-021 LAUNCH: core_start_n = 0 for exactly this one cycle, clear timeout counter, go WAIT.
REQ-022 WAIT: eop edge = core_eop & ~core_eop_q (core_eop_q registered each cycle); on edge capture core_out into res_out, core_val into res_val, set res_valid, go HOLD.
REQ-023 WAIT: timeout counter increments each cycle; reaching TIMEOUT without edge SHALL set err, set res_out=16'hFFFF, res_valid=1, go HOLD.
REQ-024 HOLD: res_out/res_val/res_valid stable; on res_ready clear res_valid, go IDLE.
REQ-025 core_val SHALL remain stable from LAUNCH until leaving WAIT.
REQ-026 core_start_n SHALL be 1 in all states except LAUNCH.
REQ-027 Only one operation outstanding; FIFO continues to accept operands during LAUNCH/WAIT/HOLD.
REQ-028 Latency: operand pushed into empty FIFO in IDLE at cycle t -> popped t+1, start pulse t+2, result res_valid one cycle after eop edge.
REQ-029 err SHALL remain 1 until reset; subsequent operations SHALL proceed normally.
REQ-030 Operand 0 and 32'hFFFFFFFF SHALL pass unmodified to core_val.

Reset
REQ-031 rst=0 SHALL asynchronously force: state IDLE, FIFO empty, in_ready=1, core_start_n=1, core_val=0, res_out=0, res_val=0, res_valid=0, err=0, core_eop_q=0, counter=0.
REQ-032 Reset mid-operation SHALL discard FIFO contents and any in-flight result; no result emitted for them.
REQ-033 After rst deasserts, first start pulse SHALL occur only after a new push.

Verification
REQ-034 Push 0,15,16,65535 with res_ready=1 and behavioural core (floor sqrt, eop after 10 cycles) -> res_out 0,3,4,255 in order, res_val echoes operands.
REQ-035 Push 32'hFFFFFFFF -> res_out=65535; core_start_n low exactly one cycle per operand.
REQ-036 Hold res_ready=0, push DEPTH+1 operands -> in_ready=0 once FIFO full with one in flight; release -> all results delivered, none lost or duplicated.
REQ-037 Core never asserts eop -> after 64 WAIT cycles err=1, res_out=16'hFFFF; next operand 9 -> res_out=3, err stays 1.
REQ-038 Assert rst during WAIT with 3 queued -> all outputs at reset values immediately; no res_valid until new push.
REQ-039 Push during same cycle FIFO pops (count=DEPTH-1 steady) -> ordering preserved, count correct.

Source files
------------

// File: rtl/sqrt_dispatch_if.sv
// Bundles the operand stream, sqrt-core and result handshake signals of sqrt_dispatch.
// The slave modport is the dispatcher's view; master is the environment's view.
interface sqrt_dispatch_if;
  logic [31:0] in_val;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] core_val;
  logic        core_start_n;
  logic [15:0] core_out;
  logic        core_eop;
  logic [15:0] res_out;
  logic [31:0] res_val;
  logic        res_valid;
  logic        res_ready;
  logic        err;

  modport slave (
    input  in_val, in_valid, core_out, core_eop, res_ready,
    output in_ready, core_val, core_start_n, res_out, res_val, res_valid, err
  );

  modport master (
    output in_val, in_valid, core_out, core_eop, res_ready,
    input  in_ready, core_val, core_start_n, res_out, res_val, res_valid, err
  );
endinterface

// File: rtl/sqrt_dispatch.sv
// Queues operands in a small FIFO and feeds them one at a time to an external sqrt core,
// holding each result (or a timeout marker) until the consumer takes it.
module sqrt_dispatch #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  sqrt_dispatch_if.slave bus_io
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StHold} state_e;

  state_e          state_q, state_d;
  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     core_val_q, core_val_d;
  logic [15:0]     res_out_q, res_out_d;
  logic [31:0]     res_val_q, res_val_d;
  logic            res_valid_q, res_valid_d;
  logic            err_q, err_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            core_eop_q;

  logic full, empty, push, pop, eop_edge;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = bus_io.in_valid & ~full;
  assign pop      = (state_q == StIdle) & ~empty;
  assign eop_edge = bus_io.core_eop & ~core_eop_q;

  // FIFO storage and occupancy; simultaneous push and pop leave the count unchanged.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus_io.in_val;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    core_val_d  = core_val_q;
    res_out_d   = res_out_q;
    res_val_d   = res_val_q;
    res_valid_d = res_valid_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          core_val_d = mem_q[rd_ptr_q];
          state_d    = StLaunch;
        end
      end
      StLaunch: begin
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (eop_edge) begin
          res_out_d   = bus_io.core_out;
          res_val_d   = core_val_q;
          res_valid_d = 1'b1;
          state_d     = StHold;
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          // Core never finished: flag it and hand back an all-ones marker result.
          err_d       = 1'b1;
          res_out_d   = 16'hFFFF;
          res_val_d   = core_val_q;
          res_valid_d = 1'b1;
          state_d     = StHold;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StHold: begin
        if (bus_io.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      core_val_q  <= '0;
      res_out_q   <= '0;
      res_val_q   <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
      core_eop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      core_val_q  <= core_val_d;
      res_out_q   <= res_out_d;
      res_val_q   <= res_val_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      core_eop_q  <= bus_io.core_eop;
    end
  end

  assign bus_io.in_ready     = ~full;
  assign bus_io.core_val     = core_val_q;
  assign bus_io.core_start_n = (state_q != StLaunch);
  assign bus_io.res_out      = res_out_q;
  assign bus_io.res_val      = res_val_q;
  assign bus_io.res_valid    = res_valid_q;
  assign bus_io.err          = err_q;
endmodule

// File: tb/tb_sqrt_dispatch.sv
// Directed bench for sqrt_dispatch with a behavioural sqrt core (eop level 10 cycles after start).
module tb_sqrt_dispatch;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned TIMEOUT  = 64;
  localparam int          EopDelay = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sqrt_dispatch_if bus ();

  sqrt_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] got_out [$];
  logic [31:0] got_val [$];
  int          starts      = 0;
  int          long_pulses = 0;
  logic        prev_low    = 1'b0;

  logic core_busy  = 1'b0;
  int   core_cnt   = 0;
  logic core_eop_r = 1'b0;
  logic core_hang  = 1'b0;

  function automatic logic [15:0] isqrt(input logic [31:0] v);
    logic [15:0] r = '0;
    logic [15:0] t;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if (32'(t) * 32'(t) <= v) r = t;
    end
    return r;
  endfunction

  assign bus.core_out = isqrt(bus.core_val);
  assign bus.core_eop = core_eop_r;

  // Behavioural core: held in reset by core_start_n, raises eop EopDelay cycles later.
  always @(posedge clk) begin
    if (!bus.core_start_n) begin
      core_busy  <= 1'b1;
      core_cnt   <= 0;
      core_eop_r <= 1'b0;
    end else if (core_busy) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == EopDelay - 1) begin
        core_busy <= 1'b0;
        if (!core_hang) core_eop_r <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.res_valid && bus.res_ready) begin
      got_out.push_back(bus.res_out);
      got_val.push_back(bus.res_val);
    end
    if (!bus.core_start_n) starts <= starts + 1;
    if (!bus.core_start_n && prev_low) long_pulses <= long_pulses + 1;
    prev_low <= !bus.core_start_n;
  end

  // Call only just after a rising edge; returns one step after the accepting edge.
  task automatic push(input logic [31:0] v);
    int n = 0;
    bus.in_val   = v;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL push_accept val=%0h in_ready=%b want 1", v, bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int k = 0;
    while (got_out.size() < n && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors += 7;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
    if (bus.core_start_n !== 1'b1) begin miscompares++; $display("FAIL rst_start_n got=%b want=1", bus.core_start_n); end
    if (bus.core_val !== 32'd0) begin miscompares++; $display("FAIL rst_core_val got=%0h want=0", bus.core_val); end
    if (bus.res_out !== 16'd0) begin miscompares++; $display("FAIL rst_res_out got=%0h want=0", bus.res_out); end
    if (bus.res_val !== 32'd0) begin miscompares++; $display("FAIL rst_res_val got=%0h want=0", bus.res_val); end
    if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_res_valid got=%b want=0", bus.res_valid); end
    if (bus.err !== 1'b0) begin miscompares++; $display("FAIL rst_err got=%b want=0", bus.err); end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency;
    int n = 0;
    bus.res_ready = 1'b1;
    push(32'd100);
    @(negedge clk);
    vectors++;
    if (bus.core_start_n !== 1'b1) begin miscompares++; $display("FAIL lat_pop_cycle start_n=%b want=1", bus.core_start_n); end
    @(negedge clk);
    vectors += 2;
    if (bus.core_start_n !== 1'b0) begin miscompares++; $display("FAIL lat_start start_n=%b want=0", bus.core_start_n); end
    if (bus.core_val !== 32'd100) begin miscompares++; $display("FAIL lat_core_val got=%0d want=100", bus.core_val); end
    @(negedge clk);
    vectors++;
    if (bus.core_start_n !== 1'b1) begin miscompares++; $display("FAIL lat_start_end start_n=%b want=1", bus.core_start_n); end
    while (bus.core_eop !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors += 2;
    if (bus.core_eop !== 1'b1) begin miscompares++; $display("FAIL lat_eop_seen got=%b want=1", bus.core_eop); end
    if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL lat_early_valid got=%b want=0", bus.res_valid); end
    @(negedge clk);
    vectors += 3;
    if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL lat_valid got=%b want=1", bus.res_valid); end
    if (bus.res_out !== 16'd10) begin miscompares++; $display("FAIL lat_res_out got=%0d want=10", bus.res_out); end
    if (bus.res_val !== 32'd100) begin miscompares++; $display("FAIL lat_res_val got=%0d want=100", bus.res_val); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    logic [31:0] ops [5];
    logic [15:0] exp [5];
    int base = got_out.size();
    int s0   = starts;
    int l0   = long_pulses;
    ops = '{32'd0, 32'd15, 32'd16, 32'd65535, 32'hFFFF_FFFF};
    exp = '{16'd0, 16'd3, 16'd4, 16'd255, 16'hFFFF};
    bus.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(ops[i]);
    wait_results(base + 5);
    vectors++;
    if (got_out.size() != base + 5) begin
      miscompares++;
      $display("FAIL basic_count got=%0d want=%0d", got_out.size() - base, 5);
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors += 2;
        if (got_out[base+i] !== exp[i]) begin miscompares++; $display("FAIL basic_out[%0d] got=%0h want=%0h", i, got_out[base+i], exp[i]); end
        if (got_val[base+i] !== ops[i]) begin miscompares++; $display("FAIL basic_val[%0d] got=%0h want=%0h", i, got_val[base+i], ops[i]); end
      end
    end
    vectors += 2;
    if (starts - s0 != 5) begin miscompares++; $display("FAIL basic_starts got=%0d want=5", starts - s0); end
    if (long_pulses != l0) begin miscompares++; $display("FAIL basic_pulse_len extra=%0d want=0", long_pulses - l0); end
  endtask

  task automatic test_backpressure;
    logic [31:0] ops [5];
    logic [15:0] exp [5];
    int base = got_out.size();
    ops = '{32'd1, 32'd4, 32'd9, 32'd25, 32'd36};
    exp = '{16'd1, 16'd2, 16'd3, 16'd5, 16'd6};
    bus.res_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH) + 1; i++) push(ops[i]);
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full in_ready=%b want=0", bus.in_ready); end
    repeat (20) @(negedge clk);
    vectors += 3;
    if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid got=%b want=1", bus.res_valid); end
    if (bus.res_out !== 16'd1) begin miscompares++; $display("FAIL bp_hold_out got=%0d want=1", bus.res_out); end
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_still_full in_ready=%b want=0", bus.in_ready); end
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    wait_results(base + 5);
    repeat (100) @(posedge clk);
    #1;
    vectors++;
    if (got_out.size() != base + 5) begin
      miscompares++;
      $display("FAIL bp_count got=%0d want=5", got_out.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors += 2;
        if (got_out[base+i] !== exp[i]) begin miscompares++; $display("FAIL bp_out[%0d] got=%0d want=%0d", i, got_out[base+i], exp[i]); end
        if (got_val[base+i] !== ops[i]) begin miscompares++; $display("FAIL bp_val[%0d] got=%0d want=%0d", i, got_val[base+i], ops[i]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ops [8];
    int base = got_out.size();
    int n;
    ops = '{32'd100, 32'd121, 32'd144, 32'd169, 32'd196, 32'd225, 32'd256, 32'd289};
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(ops[i]);
    for (int i = 4; i < 8; i++) begin
      n = 0;
      @(negedge clk);
      while (bus.res_valid !== 1'b1 && n < 300) begin
        @(negedge clk);
        n++;
      end
      vectors++;
      if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_wait[%0d] res_valid=%b want=1", i, bus.res_valid); end
      @(posedge clk);
      #1;
      // FSM is in IDLE popping this cycle; push lands on the same edge.
      bus.in_val   = ops[i];
      bus.in_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_pre[%0d] got=%b want=1", i, bus.in_ready); end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_post[%0d] got=%b want=1", i, bus.in_ready); end
      @(posedge clk);
      #1;
    end
    wait_results(base + 8);
    vectors++;
    if (got_out.size() != base + 8) begin
      miscompares++;
      $display("FAIL b2b_count got=%0d want=8", got_out.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors += 2;
        if (got_out[base+i] !== 16'(10 + i)) begin miscompares++; $display("FAIL b2b_out[%0d] got=%0d want=%0d", i, got_out[base+i], 10 + i); end
        if (got_val[base+i] !== ops[i]) begin miscompares++; $display("FAIL b2b_val[%0d] got=%0d want=%0d", i, got_val[base+i], ops[i]); end
      end
    end
  endtask

  task automatic test_timeout;
    int base = got_out.size();
    int n = 0;
    bus.res_ready = 1'b1;
    core_hang     = 1'b1;
    push(32'd7);
    @(negedge clk);
    while (bus.core_start_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.err !== 1'b0) begin miscompares++; $display("FAIL tmo_err_pre got=%b want=0", bus.err); end
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    vectors += 3;
    if (n != int'(TIMEOUT) + 1) begin miscompares++; $display("FAIL tmo_cycles got=%0d want=%0d", n, TIMEOUT + 1); end
    if (bus.err !== 1'b1) begin miscompares++; $display("FAIL tmo_err got=%b want=1", bus.err); end
    if (bus.res_out !== 16'hFFFF) begin miscompares++; $display("FAIL tmo_res_out got=%0h want=ffff", bus.res_out); end
    @(posedge clk);
    #1;
    core_hang = 1'b0;
    push(32'd9);
    wait_results(base + 2);
    vectors++;
    if (got_out.size() != base + 2) begin
      miscompares++;
      $display("FAIL tmo_count got=%0d want=2", got_out.size() - base);
    end else begin
      vectors += 2;
      if (got_out[base+1] !== 16'd3) begin miscompares++; $display("FAIL tmo_next_out got=%0d want=3", got_out[base+1]); end
      if (got_val[base+1] !== 32'd9) begin miscompares++; $display("FAIL tmo_next_val got=%0d want=9", got_val[base+1]); end
    end
    @(negedge clk);
    vectors++;
    if (bus.err !== 1'b1) begin miscompares++; $display("FAIL tmo_err_sticky got=%b want=1", bus.err); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int base;
    int s0;
    bus.res_ready = 1'b1;
    push(32'd50);
    push(32'd60);
    push(32'd70);
    push(32'd80);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    vectors += 7;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_in_ready got=%b want=1", bus.in_ready); end
    if (bus.core_start_n !== 1'b1) begin miscompares++; $display("FAIL rmid_start_n got=%b want=1", bus.core_start_n); end
    if (bus.core_val !== 32'd0) begin miscompares++; $display("FAIL rmid_core_val got=%0d want=0", bus.core_val); end
    if (bus.res_out !== 16'd0) begin miscompares++; $display("FAIL rmid_res_out got=%0d want=0", bus.res_out); end
    if (bus.res_val !== 32'd0) begin miscompares++; $display("FAIL rmid_res_val got=%0d want=0", bus.res_val); end
    if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_res_valid got=%b want=0", bus.res_valid); end
    if (bus.err !== 1'b0) begin miscompares++; $display("FAIL rmid_err got=%b want=0", bus.err); end
    base = got_out.size();
    s0   = starts;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    vectors += 2;
    if (got_out.size() != base) begin miscompares++; $display("FAIL rmid_no_result got=%0d want=0", got_out.size() - base); end
    if (starts != s0) begin miscompares++; $display("FAIL rmid_no_start got=%0d want=0", starts - s0); end
    push(32'd81);
    wait_results(base + 1);
    vectors++;
    if (got_out.size() != base + 1) begin
      miscompares++;
      $display("FAIL rmid_new_count got=%0d want=1", got_out.size() - base);
    end else begin
      vectors++;
      if (got_out[base] !== 16'd9) begin miscompares++; $display("FAIL rmid_new_out got=%0d want=9", got_out[base]); end
    end
  endtask

  initial begin
    bus.in_val    = '0;
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
    rst           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_latency;
    test_basic;
    test_backpressure;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout bench did not complete, want completion");
    $fatal(1, "bench time limit reached");
  end
endmodule
